// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT = 10;
  localparam int ITER_DIV_LAT    = 33;
  localparam int CNT_W           = 16;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is correct as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_divider_iter.sv
// Unsigned 32/32 restoring divider: one load cycle, then one quotient bit per cycle.
module md_divider_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        active_q, active_d;
  logic [5:0]  step_q, step_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    active_d = active_q;
    step_d   = step_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    rem_sh   = {rem_q, quo_q[31]};
    diff     = rem_sh - {1'b0, dvs_q};
    if (cancel) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      step_d   = 6'd32;
      quo_d    = dividend;
      rem_d    = 32'd0;
      dvs_d    = divisor;
    end else if (active_q) begin
      if (step_q != 6'd0) begin
        // diff[32] set means the shifted remainder was below the divisor: restore.
        rem_d  = diff[32] ? rem_sh[31:0] : diff[31:0];
        quo_d  = {quo_q[30:0], ~diff[32]};
        step_d = step_q - 6'd1;
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      step_q   <= 6'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
    end else begin
      active_q <= active_d;
      step_q   <= step_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
    end
  end

  assign done      = active_q && (step_q == 6'd0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers.
// Define MDU_ITER_DIV_EN to use the iterative restoring divider (33-cycle DIV/DIVU).
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  input  logic        hilo_write,
  input  logic        hilo_sel,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef MDU_ITER_DIV_EN
  localparam int DIV_CYCLES = ITER_DIV_LAT;
`else
  localparam int DIV_CYCLES = DIV_LAT;
`endif

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0] ext_a, ext_b, product;
  logic [31:0] q_u, r_u, quot, rem;
  logic [31:0] res_hi, res_lo;
  logic        last;

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign ext_a   = {{32{op_q[0] & a_q[31]}}, a_q};
  assign ext_b   = {{32{op_q[0] & b_q[31]}}, b_q};
  assign product = ext_a * ext_b;

`ifdef MDU_ITER_DIV_EN
  logic div_start;
  logic div_done;

  assign div_start = (state_q == IDLE) & md_start & ~hilo_write & md_op[1];

  md_divider_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (mag32(src_a, md_op[0])),
    .divisor   (mag32(src_b, md_op[0])),
    .cancel    (hilo_write),
    .done      (div_done),
    .quotient  (q_u),
    .remainder (r_u)
  );

  assign last = op_q[1] ? div_done : (cnt_q == CNT_W'(1));
`else
  logic [31:0] mag_a, mag_b, mag_b_safe;

  assign mag_a      = mag32(a_q, op_q[0]);
  assign mag_b      = mag32(b_q, op_q[0]);
  assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_u        = mag_a / mag_b_safe;
  assign r_u        = mag_a % mag_b_safe;
  assign last       = (cnt_q == CNT_W'(1));
`endif

  // Quotient negative when signs differ; remainder follows the dividend's sign.
  assign quot = (op_q[0] & (a_q[31] ^ b_q[31])) ? (32'd0 - q_u) : q_u;
  assign rem  = (op_q[0] & a_q[31]) ? (32'd0 - r_u) : r_u;

  always_comb begin
    if (!op_q[1]) begin
      res_hi = product[63:32];
      res_lo = product[31:0];
    end else if (b_q == 32'd0) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    // A HI/LO write always takes priority and aborts anything in flight.
    if (hilo_write) begin
      if (hilo_sel) hi_d = src_a;
      else          lo_d = src_a;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            a_d     = src_a;
            b_d     = src_b;
            op_d    = md_op;
            cnt_d   = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_LAT);
            state_d = RUN;
          end
        end
        RUN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (last) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= MD_MULTU;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO, a negedge monitor pops and checks.
module tb_md_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef MDU_ITER_DIV_EN
  localparam int DLAT = 33;
`else
  localparam int DLAT = DIV_LAT;
`endif

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [1:0]  md_op;
  logic        hilo_write;
  logic        hilo_sel;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mark;

  int checks = 0;
  int passes = 0;

  string       name_q[$];
  logic [31:0] ehi_q[$];
  logic [31:0] elo_q[$];
  int          lat_q[$];

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_start   (md_start),
    .md_op      (md_op),
    .hilo_write (hilo_write),
    .hilo_sel   (hilo_sel),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic straight from the operation definitions.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: return sa * sb;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l, input int lat);
    name_q.push_back(nm);
    ehi_q.push_back(h);
    elo_q.push_back(l);
    lat_q.push_back(lat);
  endtask

  task automatic pop_check(input bit is_mark, input int run);
    string nm;
    int    lat;
    if (name_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_output: got hi=0x%08h lo=0x%08h expected no event", hi, lo);
      return;
    end
    nm  = name_q.pop_front();
    lat = lat_q.pop_front();
    chk({nm, "_hi"}, hi, ehi_q.pop_front());
    chk({nm, "_lo"}, lo, elo_q.pop_front());
    if (lat >= 0) chk({nm, "_busy_cycles"}, 32'(run), 32'(lat));
    if (is_mark)  chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    $display("txn %-22s hi=0x%08h lo=0x%08h busy_cycles=%0d", nm, hi, lo, run);
  endtask

  // Monitor: a falling busy is an output event; otherwise a stimulus mark requests a check.
  initial begin
    bit busy_prev;
    int run;
    busy_prev = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) run++;
      if (busy_prev && busy !== 1'b1) pop_check(1'b0, run);
      else if (mark) pop_check(1'b1, run);
      if (busy !== 1'b1) run = 0;
      busy_prev = (busy === 1'b1);
    end
  end

  task automatic mark_check(input string nm);
    push(nm, m_hi, m_lo, -1);
    mark = 1'b1;
    @(posedge clk);
    #1 mark = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (busy === 1'b0) passes++;
    else $display("FAIL %s_timeout: busy still %b after %0d cycles, expected 0", nm, busy, n);
  endtask

  task automatic issue_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit extra_start);
    logic [63:0] r;
    r = model(op, a, b);
    @(posedge clk);
    #1;
    md_start = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    push(nm, r[63:32], r[31:0], op[1] ? DLAT : MUL_LAT);
    m_hi = r[63:32];
    m_lo = r[31:0];
    @(posedge clk);
    #1;
    md_start = 1'b0;
    md_op    = 2'($urandom_range(0, 3));
    src_a    = $urandom;
    src_b    = $urandom;
    if (extra_start) begin
      md_start = 1'b1;
      @(posedge clk);
      #1 md_start = 1'b0;
    end
    wait_idle(nm);
  endtask

  task automatic hilo_wr(input string nm, input logic sel, input logic [31:0] d, input bit also_start);
    @(posedge clk);
    #1;
    hilo_write = 1'b1;
    hilo_sel   = sel;
    src_a      = d;
    src_b      = $urandom;
    md_op      = 2'($urandom_range(0, 3));
    md_start   = also_start;
    if (sel) m_hi = d;
    else     m_lo = d;
    @(posedge clk);
    #1;
    hilo_write = 1'b0;
    md_start   = 1'b0;
    mark_check(nm);
  endtask

  initial begin
    reset      = 1'b1;
    md_start   = 1'b0;
    md_op      = 2'd0;
    hilo_write = 1'b0;
    hilo_sel   = 1'b0;
    src_a      = 32'd0;
    src_b      = 32'd0;
    mark       = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mark_check("reset_state");

    issue_op("mult_m2x3",     2'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue_op("multu_fffex3",  2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue_op("div_m7_2",      2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue_op("divu_7_2",      2'd2, 32'd7, 32'd2, 1'b0);
    issue_op("divu_by_zero",  2'd2, 32'h1234_5678, 32'd0, 1'b0);
    issue_op("div_by_zero",   2'd3, 32'h8000_0001, 32'd0, 1'b0);
    issue_op("div_min_m1",    2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    hilo_wr("mthi",           1'b1, 32'hAAAA_0000, 1'b0);
    hilo_wr("mtlo",           1'b0, 32'h0000_5555, 1'b0);
    hilo_wr("mtlo_with_start", 1'b0, 32'h0000_0077, 1'b1);

    // Cancel: MULT 3x4 started, MTHI 1 applied two edges later.
    @(posedge clk);
    #1;
    md_start = 1'b1; md_op = 2'd1; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk);
    #1 md_start = 1'b0;
    @(posedge clk);
    #1;
    hilo_write = 1'b1; hilo_sel = 1'b1; src_a = 32'd1;
    push("cancel_mthi", 32'd1, m_lo, 2);
    m_hi = 32'd1;
    @(posedge clk);
    #1 hilo_write = 1'b0;
    repeat (12) @(posedge clk);
    #1 mark_check("no_late_commit");

    issue_op("start_while_busy", 2'd0, 32'h0001_0010, 32'h0000_0020, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int          sel;
      logic [31:0] a, b;
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      if (sel < 2) hilo_wr("rand_hilo", 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)));
      else issue_op("rand_op", 2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a DIV.
    @(posedge clk);
    #1;
    md_start = 1'b1; md_op = 2'd3; src_a = 32'h0000_1000; src_b = 32'd3;
    @(posedge clk);
    #1 md_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    push("reset_mid_div", 32'd0, 32'd0, -1);
    m_hi = 32'd0;
    m_lo = 32'd0;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_hi", hi, 32'd0);
    chk("async_reset_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    #1 mark_check("reset_no_commit");

    repeat (5) @(posedge clk);
    checks++;
    if (name_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", name_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Execute-stage multiply/divide unit with architectural HI/LO registers. It consumes MdOp, IsMd, HiLoWrite and HiLo from the decode controller, carried through the D/E pipeline register, along with the forwarded E-stage operands. Multi-cycle MULT/MULTU/DIV/DIVU set busy, which the hazard unit uses to stall any following IsMd instruction in D. It also services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.

Parameters:
MUL_LAT, 5, cycles from start sample to HI/LO commit for MULT/MULTU (≥1)
DIV_LAT, 10, cycles from start sample to HI/LO commit for DIV/DIVU (≥1; ignored when MDU_ITER_DIV_EN is defined)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
md_start  in  1  start a mult/div this cycle (IsMdE & ~HiLoWriteE & ~RegWriteE)
md_op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
hilo_write  in  1  MTHI/MTLO write this cycle
hilo_sel  in  1  1 = HI, 0 = LO (target of hilo_write)
src_a  in  32  rs operand: multiplicand/dividend, or MTHI/MTLO data
src_b  in  32  rt operand: multiplier/divisor
busy  out  1  operation in flight
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (async, active-high): hi=0, lo=0, busy=0, counter=0, state IDLE. Reset asserted mid-operation discards the operation; no commit occurs.
- FSM states: IDLE and RUN.
  - IDLE → RUN on the edge where md_start=1. At that edge, src_a, src_b and md_op are latched, and counter loads MUL_LAT or DIV_LAT.
  - RUN decrements counter each edge. When counter reaches 1, the next edge commits {hi,lo} and returns to IDLE.
- busy is registered: busy=1 exactly while the FSM is in RUN. An op sampled at edge T commits at edge T+LAT, and busy falls at that same edge.
- Operands are held in internal registers, so src_a/src_b may change after the start edge.
- MULTU: {hi,lo} = 64-bit unsigned product. MULT: 64-bit two's-complement product.
- DIVU: lo = unsigned quotient, hi = unsigned remainder.
- DIV: quotient truncated toward zero, remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (both DIV and DIVU): lo=0xFFFFFFFF, hi=src_a. The result is deterministic; no exception is raised.
- hilo_write in IDLE: hi or lo (per hilo_sel) takes src_a at the edge; the other register is unchanged.
- hilo_write in RUN: the pending operation is cancelled and the write is applied. At that edge busy→0 and the FSM returns to IDLE.
- md_start in RUN is ignored. The hazard unit guarantees it does not occur; the bench checks that it is ignored.
- md_start and hilo_write in the same cycle: hilo_write wins, and no operation starts.
- hi/lo outputs are registered values with no internal bypass. The commit edge updates the values visible to the following cycle.

Optional Feature:
MDU_ITER_DIV_EN
- Defined: DIV/DIVU run on a 1-bit-per-cycle restoring divider (submodule).
  - Operands are converted to magnitudes at start, and signs are fixed up at commit.
  - Latency is fixed at 33 cycles: 1 setup cycle plus 32 iterations.
  - Divide-by-zero results and cancel-on-hilo_write behaviour are identical to the behavioural path.
- Not defined: the quotient and remainder are computed with behavioural operators on the latched operands, and DIV_LAT provides the latency.

Decomposition:
- Shared package md_pkg:
  - md_op encodings: MD_MULTU=2'b00, MD_MULT=2'b01, MD_DIVU=2'b10, MD_DIV=2'b11.
  - FSM state encodings: IDLE, RUN.
  - Default latencies: MUL_LAT, DIV_LAT, and ITER_DIV_LAT=33.
- One submodule, md_divider_iter: unsigned 32/32 restoring divider.
  - Inputs: start, dividend, divisor, cancel.
  - Outputs: done, quotient, remainder.
  - Instantiated only under MDU_ITER_DIV_EN.

Test Plan:
- MULT, src_a=0xFFFFFFFE (−2), src_b=3: busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. The same operands with MULTU give hi=0x00000002, lo=0xFFFFFFFA.
- DIV, src_a=0xFFFFFFF9 (−7), src_b=2: after DIV_LAT (or 33 cycles with the macro defined), lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 gives lo=3, hi=1.
- DIVU with src_b=0, src_a=0x12345678: lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- MTHI 0xAAAA0000 in IDLE, then MTLO 0x5555: hi=0xAAAA0000, lo=0x00005555, busy stays 0.
- Start MULT 3×4, then hilo_write(HI, 0x1) two cycles later: busy falls at that edge, hi=1, lo keeps its previous value, and no later commit occurs. A second md_start pulsed while busy is ignored (result matches the first op).
- Assert reset asynchronously mid-DIV (between clock edges): hi=lo=0 and busy=0 immediately; after release, no commit ever appears.
